count_flips_multi: RTL and testbench

- Parametrised successor to the single-line flip counter in the marker-detect path.
- Consumes the compressed per-pixel colour code (CHANNELS bits) from rgb_compress, one scanline at a time.
- Counts debounced colour-code transitions and records the first/last flip coordinates.
- Presents one result per line to the marker-candidate logic over a valid/ready handshake.

---
 rtl/marker_pkg.sv | 28 ++
 rtl/flip_debounce.sv | 79 +++++++
 rtl/count_flips_multi.sv | 193 +++++++++++++++++++
 tb/tb_count_flips_multi.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/marker_pkg.sv
// Shared types and default line geometry for the multi-channel flip counter.
package marker_pkg;

   localparam int DEF_CHANNELS  = 3;
   localparam int DEF_LINE_LEN  = 1050;
   localparam int DEF_MAX_FLIPS = 15;

   typedef logic [DEF_CHANNELS-1:0] pix_code_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } flip_state_t;

   // Width needed to count a candidate run up to min_run inclusive.
   function automatic int run_width(input int min_run);
      int w;
      w = $clog2(min_run + 1);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/flip_debounce.sv
// Debounce of colour-code changes: a new code must persist for MIN_RUN
// accepted pixels before it becomes the reference and a flip is committed.
module flip_debounce
   import marker_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int COORD_W  = 11,
   parameter int MIN_RUN  = 2
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                clear_i,
   input  logic                step_i,
   input  logic [CHANNELS-1:0] code_i,
   input  logic [COORD_W-1:0]  coord_i,
   output logic                commit_o,
   output logic [COORD_W-1:0]  commit_coord_o
);

   localparam int RUN_W = run_width(MIN_RUN);
   localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(MIN_RUN);

   logic [CHANNELS-1:0] ref_q,   ref_d;
   logic [CHANNELS-1:0] cand_q,  cand_d;
   logic [RUN_W-1:0]    len_q,   len_d;
   logic [COORD_W-1:0]  start_q, start_d;
   logic                commit_s;

   // Candidate tracking; the commit fires in the same cycle the run completes.
   always_comb begin
      ref_d    = ref_q;
      cand_d   = cand_q;
      len_d    = len_q;
      start_d  = start_q;
      commit_s = 1'b0;
      if (clear_i) begin
         ref_d = code_i;
         len_d = {RUN_W{1'b0}};
      end else if (step_i) begin
         if (code_i == ref_q) begin
            len_d = {RUN_W{1'b0}};
         end else if ((len_q == {RUN_W{1'b0}}) || (code_i != cand_q)) begin
            cand_d  = code_i;
            len_d   = RUN_W'(1);
            start_d = coord_i;
         end else begin
            len_d = len_q + RUN_W'(1);
         end
         if (len_d == RUN_TGT) begin
            commit_s = 1'b1;
            ref_d    = cand_d;
            len_d    = {RUN_W{1'b0}};
         end else begin
            commit_s = 1'b0;
         end
      end else begin
         len_d = len_q;
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ref_q   <= {CHANNELS{1'b0}};
         cand_q  <= {CHANNELS{1'b0}};
         len_q   <= {RUN_W{1'b0}};
         start_q <= {COORD_W{1'b0}};
      end else begin
         ref_q   <= ref_d;
         cand_q  <= cand_d;
         len_q   <= len_d;
         start_q <= start_d;
      end
   end

   assign commit_o       = commit_s;
   assign commit_coord_o = start_d;

endmodule

// File: rtl/count_flips_multi.sv
// Per-scanline colour-flip counter with first/last flip coordinates and a
// valid/ready result port. Define RUN_STATS_EN to add min/max run outputs.
module count_flips_multi
   import marker_pkg::*;
#(
   parameter int CHANNELS  = DEF_CHANNELS,
   parameter int COORD_W   = 11,
   parameter int LINE_LEN  = DEF_LINE_LEN,
   parameter int MAX_FLIPS = DEF_MAX_FLIPS,
   parameter int FLIPS_W   = 4,
   parameter int MIN_RUN   = 2
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                sol_in,
   input  logic                pix_valid_in,
   output logic                pix_ready_out,
   input  logic [CHANNELS-1:0] rgb_in,
   output logic                res_valid_out,
   input  logic                res_ready_in,
   output logic [FLIPS_W-1:0]  number_of_flips_out,
   output logic [COORD_W-1:0]  first_coord_out,
   output logic [COORD_W-1:0]  last_coord_out,
`ifdef RUN_STATS_EN
   output logic [COORD_W-1:0]  min_run_out,
   output logic [COORD_W-1:0]  max_run_out,
`endif
   output logic                done_out
);

   localparam logic [COORD_W-1:0] LAST_COORD = COORD_W'(LINE_LEN - 1);
   localparam logic [FLIPS_W-1:0] FLIPS_MAX  = FLIPS_W'(MAX_FLIPS);
   localparam flip_state_t        START_ST   = (LINE_LEN == 1) ? HOLD : SCAN;

   flip_state_t          state_q, state_d;
   logic [COORD_W-1:0]   coord_q, coord_d;
   logic [FLIPS_W-1:0]   flips_q, flips_d;
   logic [COORD_W-1:0]   first_q, first_d;
   logic [COORD_W-1:0]   last_q,  last_d;
   logic                 accept_s;
   logic                 start_s;
   logic                 step_s;
   logic                 commit_s;
   logic [COORD_W-1:0]   commit_coord_s;

   // coord_q is the coordinate of the next pixel; the sol pixel itself is 0.
   assign accept_s = pix_valid_in && (state_q != HOLD);
   assign start_s  = accept_s && sol_in;
   assign step_s   = accept_s && !sol_in && (state_q == SCAN);

   flip_debounce #(
      .CHANNELS (CHANNELS),
      .COORD_W  (COORD_W),
      .MIN_RUN  (MIN_RUN)
   ) u_debounce (
      .clk_i          (clk_in),
      .rst_n_i        (rst_n_in),
      .clear_i        (start_s),
      .step_i         (step_s),
      .code_i         (rgb_in),
      .coord_i        (coord_q),
      .commit_o       (commit_s),
      .commit_coord_o (commit_coord_s)
   );

   // Line FSM and flip bookkeeping.
   always_comb begin
      state_d = state_q;
      coord_d = coord_q;
      flips_d = flips_q;
      first_d = first_q;
      last_d  = last_q;
      case (state_q)
         IDLE, SCAN: begin
            if (start_s) begin
               state_d = START_ST;
               coord_d = COORD_W'(1);
               flips_d = {FLIPS_W{1'b0}};
               first_d = {COORD_W{1'b0}};
               last_d  = {COORD_W{1'b0}};
            end else if (step_s) begin
               coord_d = (coord_q == LAST_COORD) ? coord_q : coord_q + COORD_W'(1);
               if (commit_s) begin
                  flips_d = flips_q + FLIPS_W'(1);
                  last_d  = commit_coord_s;
                  first_d = (flips_q == {FLIPS_W{1'b0}}) ? commit_coord_s : first_q;
               end else begin
                  flips_d = flips_q;
               end
               if ((flips_d == FLIPS_MAX) || (coord_q == LAST_COORD)) begin
                  state_d = HOLD;
               end else begin
                  state_d = SCAN;
               end
            end else begin
               state_d = state_q;
            end
         end
         HOLD: begin
            if (res_ready_in) begin
               state_d = IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Line state registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         coord_q <= {COORD_W{1'b0}};
         flips_q <= {FLIPS_W{1'b0}};
         first_q <= {COORD_W{1'b0}};
         last_q  <= {COORD_W{1'b0}};
      end else begin
         state_q <= state_d;
         coord_q <= coord_d;
         flips_q <= flips_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

`ifdef RUN_STATS_EN
   logic [COORD_W-1:0] run_s;
   logic [COORD_W-1:0] rmin_q, rmin_d;
   logic [COORD_W-1:0] rmax_q, rmax_d;
   logic [COORD_W-1:0] min_out_q, min_out_d;
   logic [COORD_W-1:0] max_out_q, max_out_d;

   // last_q is zero until the first flip, so the first run is measured from 0.
   assign run_s = commit_coord_s - last_q;

   // Run-length extremes; published only once a second flip exists.
   always_comb begin
      rmin_d    = rmin_q;
      rmax_d    = rmax_q;
      min_out_d = min_out_q;
      max_out_d = max_out_q;
      if (start_s) begin
         rmin_d    = {COORD_W{1'b0}};
         rmax_d    = {COORD_W{1'b0}};
         min_out_d = {COORD_W{1'b0}};
         max_out_d = {COORD_W{1'b0}};
      end else if (step_s && commit_s) begin
         if (flips_q == {FLIPS_W{1'b0}}) begin
            rmin_d    = run_s;
            rmax_d    = run_s;
            min_out_d = {COORD_W{1'b0}};
            max_out_d = {COORD_W{1'b0}};
         end else begin
            rmin_d    = (run_s < rmin_q) ? run_s : rmin_q;
            rmax_d    = (run_s > rmax_q) ? run_s : rmax_q;
            min_out_d = rmin_d;
            max_out_d = rmax_d;
         end
      end else begin
         rmin_d = rmin_q;
      end
   end

   // Run statistics registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rmin_q    <= {COORD_W{1'b0}};
         rmax_q    <= {COORD_W{1'b0}};
         min_out_q <= {COORD_W{1'b0}};
         max_out_q <= {COORD_W{1'b0}};
      end else begin
         rmin_q    <= rmin_d;
         rmax_q    <= rmax_d;
         min_out_q <= min_out_d;
         max_out_q <= max_out_d;
      end
   end

   assign min_run_out = min_out_q;
   assign max_run_out = max_out_q;
`endif

   assign pix_ready_out       = (state_q != HOLD);
   assign res_valid_out       = (state_q == HOLD);
   assign done_out            = (state_q == HOLD) && res_ready_in;
   assign number_of_flips_out = flips_q;
   assign first_coord_out     = first_q;
   assign last_coord_out      = last_q;

endmodule

// File: tb/tb_count_flips_multi.sv
// Randomised self-checking bench for count_flips_multi against a window-based
// line model. Builds with or without RUN_STATS_EN.
module tb_count_flips_multi;

   localparam int CH        = 3;
   localparam int CW        = 11;
   localparam int LINE_LEN  = 1050;
   localparam int MAX_FLIPS = 15;
   localparam int FW        = 4;
   localparam int MIN_RUN   = 2;

   logic          clk_in = 1'b0;
   logic          rst_n_in;
   logic          sol_in;
   logic          pix_valid_in;
   logic          pix_ready_out;
   logic [CH-1:0] rgb_in;
   logic          res_valid_out;
   logic          res_ready_in;
   logic [FW-1:0] number_of_flips_out;
   logic [CW-1:0] first_coord_out;
   logic [CW-1:0] last_coord_out;
   logic          done_out;
`ifdef RUN_STATS_EN
   logic [CW-1:0] min_run_out;
   logic [CW-1:0] max_run_out;
`endif

   int errors = 0;
   int checks = 0;
   logic [CH-1:0] pix [LINE_LEN];

   count_flips_multi #(
      .CHANNELS(CH), .COORD_W(CW), .LINE_LEN(LINE_LEN),
      .MAX_FLIPS(MAX_FLIPS), .FLIPS_W(FW), .MIN_RUN(MIN_RUN)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .sol_in(sol_in),
      .pix_valid_in(pix_valid_in), .pix_ready_out(pix_ready_out), .rgb_in(rgb_in),
      .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
      .number_of_flips_out(number_of_flips_out), .first_coord_out(first_coord_out),
      .last_coord_out(last_coord_out),
`ifdef RUN_STATS_EN
      .min_run_out(min_run_out), .max_run_out(max_run_out),
`endif
      .done_out(done_out)
   );

   always #5 clk_in = ~clk_in;

   // Reference: a flip is the first window of MIN_RUN equal pixels whose code
   // differs from the current reference; the search resumes after that window.
   task automatic model_line(output int m_term, output int m_flips, output int m_first,
                             output int m_last, output int m_min, output int m_max);
      logic [CH-1:0] refc;
      int i, prev, run;
      bit win;
      refc = pix[0]; m_flips = 0; m_first = 0; m_last = 0; m_min = 0; m_max = 0;
      prev = 0; m_term = LINE_LEN - 1; i = 1;
      while (i < LINE_LEN) begin
         win = (pix[i] != refc) && (i + MIN_RUN - 1 < LINE_LEN);
         if (win) begin
            for (int k = 1; k < MIN_RUN; k++) if (pix[i+k] != pix[i]) win = 1'b0;
         end
         if (win) begin
            m_flips++;
            run = i - prev;
            if (m_flips == 1) begin m_min = run; m_max = run; m_first = i; end
            else begin
               if (run < m_min) m_min = run;
               if (run > m_max) m_max = run;
            end
            m_last = i; prev = i; refc = pix[i];
            if (m_flips == MAX_FLIPS) begin m_term = i + MIN_RUN - 1; break; end
            i = i + MIN_RUN;
         end else begin
            i++;
         end
      end
      if (m_flips < 2) begin m_min = 0; m_max = 0; end
   endtask

   task automatic gen_line(input int max_run);
      int i, len;
      logic [CH-1:0] code;
      i = 0;
      while (i < LINE_LEN) begin
         len  = $urandom_range(1, max_run);
         code = CH'($urandom_range(0, 7));
         for (int k = 0; k < len && i < LINE_LEN; k++) begin pix[i] = code; i++; end
      end
   endtask

   // Sends up to n pixels of pix[], sol on the first; stops once a result shows.
   task automatic drive_line(input int n, input bit bubbles, output int obs_term);
      obs_term = -1;
      for (int i = 0; i < n; i++) begin
         if (bubbles && $urandom_range(0, 3) == 0) begin
            @(negedge clk_in);
            pix_valid_in = 1'b0; sol_in = 1'($urandom); rgb_in = CH'($urandom);
            @(posedge clk_in);
         end
         @(negedge clk_in);
         pix_valid_in = 1'b1; sol_in = (i == 0); rgb_in = pix[i];
         @(posedge clk_in); #1;
         if (res_valid_out) begin obs_term = i; break; end
      end
      @(negedge clk_in);
      pix_valid_in = 1'b0; sol_in = 1'b0;
   endtask

   task automatic release_result(output logic done_now, output logic valid_after,
                                 output logic done_after);
      @(negedge clk_in);
      res_ready_in = 1'b1; #1;
      done_now = done_out;
      @(posedge clk_in); #1;
      valid_after = res_valid_out; done_after = done_out;
      @(negedge clk_in);
      res_ready_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0; sol_in = 1'b0; pix_valid_in = 1'b0; rgb_in = '0; res_ready_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      checks++; if (pix_ready_out !== 1'b1) begin errors++; $display("FAIL reset_pix_ready: got %b expected 1", pix_ready_out); end
      checks++; if (res_valid_out !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid_out); end
      checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_out); end
      checks++; if ({number_of_flips_out, first_coord_out, last_coord_out} !== '0) begin errors++;
         $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", number_of_flips_out, first_coord_out, last_coord_out); end
`ifdef RUN_STATS_EN
      checks++; if ({min_run_out, max_run_out} !== '0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", min_run_out, max_run_out); end
`endif
      @(negedge clk_in); rst_n_in = 1'b1;
   endtask

   task automatic test_band();
      int obs; logic d0, v1, d1;
      for (int i = 0; i < LINE_LEN; i++) pix[i] = (i >= 100 && i <= 199) ? 3'b101 : 3'b000;
      drive_line(LINE_LEN, 1'b1, obs);
      checks++; if (obs !== 1049) begin errors++; $display("FAIL band_term: got %0d expected 1049", obs); end
      checks++; if (number_of_flips_out !== 4'd2) begin errors++; $display("FAIL band_flips: got %0d expected 2", number_of_flips_out); end
      checks++; if (first_coord_out !== 11'd100) begin errors++; $display("FAIL band_first: got %0d expected 100", first_coord_out); end
      checks++; if (last_coord_out !== 11'd200) begin errors++; $display("FAIL band_last: got %0d expected 200", last_coord_out); end
      release_result(d0, v1, d1);
      checks++; if ({d0, v1, d1} !== 3'b100) begin errors++; $display("FAIL band_handshake: got done/valid/done=%b%b%b expected 100", d0, v1, d1); end
   endtask

   task automatic test_glitch();
      int obs; logic d0, v1, d1;
      for (int i = 0; i < LINE_LEN; i++) pix[i] = 3'b000;
      pix[50] = 3'b111;
      drive_line(LINE_LEN, 1'b0, obs);
      checks++; if (obs !== 1049) begin errors++; $display("FAIL glitch_term: got %0d expected 1049", obs); end
      checks++; if ({number_of_flips_out, first_coord_out, last_coord_out} !== '0) begin errors++;
         $display("FAIL glitch_counts: got %0d/%0d/%0d expected 0/0/0", number_of_flips_out, first_coord_out, last_coord_out); end
      release_result(d0, v1, d1);
   endtask

   task automatic test_max_flips();
      int obs, mt, mf, m1, ml, mn, mx; logic d0, v1, d1;
      for (int i = 0; i < LINE_LEN; i++) pix[i] = ((i / 10) % 2 == 1) ? 3'b110 : 3'b001;
      model_line(mt, mf, m1, ml, mn, mx);
      drive_line(LINE_LEN, 1'b1, obs);
      checks++; if (obs !== mt) begin errors++; $display("FAIL maxf_term: got %0d expected %0d", obs, mt); end
      checks++; if (number_of_flips_out !== 4'd15) begin errors++; $display("FAIL maxf_flips: got %0d expected 15", number_of_flips_out); end
      checks++; if (first_coord_out !== 11'd10) begin errors++; $display("FAIL maxf_first: got %0d expected 10", first_coord_out); end
      checks++; if (last_coord_out !== 11'd150) begin errors++; $display("FAIL maxf_last: got %0d expected 150", last_coord_out); end
`ifdef RUN_STATS_EN
      checks++; if ({min_run_out, max_run_out} !== {11'd10, 11'd10}) begin errors++; $display("FAIL maxf_stats: got %0d/%0d expected 10/10", min_run_out, max_run_out); end
`endif
      release_result(d0, v1, d1);
   endtask

   task automatic test_random();
      int obs, mt, mf, m1, ml, mn, mx; logic d0, v1, d1;
      for (int n = 0; n < 6; n++) begin
         gen_line((n % 2 == 0) ? 40 : 150);
         model_line(mt, mf, m1, ml, mn, mx);
         drive_line(LINE_LEN, 1'b1, obs);
         checks++; if (obs !== mt) begin errors++; $display("FAIL rand%0d_term: got %0d expected %0d", n, obs, mt); end
         checks++; if ({number_of_flips_out, first_coord_out, last_coord_out} !== {FW'(mf), CW'(m1), CW'(ml)}) begin errors++;
            $display("FAIL rand%0d_result: got %0d/%0d/%0d expected %0d/%0d/%0d", n, number_of_flips_out, first_coord_out, last_coord_out, mf, m1, ml); end
`ifdef RUN_STATS_EN
         checks++; if ({min_run_out, max_run_out} !== {CW'(mn), CW'(mx)}) begin errors++;
            $display("FAIL rand%0d_stats: got %0d/%0d expected %0d/%0d", n, min_run_out, max_run_out, mn, mx); end
`endif
         release_result(d0, v1, d1);
         checks++; if ({d0, v1, d1} !== 3'b100) begin errors++; $display("FAIL rand%0d_handshake: got %b%b%b expected 100", n, d0, v1, d1); end
      end
   endtask

   task automatic test_hold_stall();
      int obs, mt, mf, m1, ml, mn, mx, dones;
      gen_line(60);
      model_line(mt, mf, m1, ml, mn, mx);
      drive_line(LINE_LEN, 1'b0, obs);
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_in);
         pix_valid_in = 1'b1; sol_in = 1'b1; rgb_in = CH'($urandom); res_ready_in = 1'b0;
         @(posedge clk_in); #1;
         if (done_out) dones++;
         checks++; if ({pix_ready_out, res_valid_out} !== 2'b01) begin errors++; $display("FAIL stall_flags%0d: got ready/valid=%b%b expected 01", c, pix_ready_out, res_valid_out); end
         checks++; if ({number_of_flips_out, first_coord_out, last_coord_out} !== {FW'(mf), CW'(m1), CW'(ml)}) begin errors++;
            $display("FAIL stall_hold%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", c, number_of_flips_out, first_coord_out, last_coord_out, mf, m1, ml); end
      end
      @(negedge clk_in);
      res_ready_in = 1'b1; #1;
      if (done_out) dones++;
      checks++; if ({done_out, pix_ready_out} !== 2'b10) begin errors++; $display("FAIL stall_ready: got done/pix_ready=%b%b expected 10", done_out, pix_ready_out); end
      @(posedge clk_in); #1;
      if (done_out) dones++;
      checks++; if ({res_valid_out, pix_ready_out} !== 2'b01) begin errors++; $display("FAIL stall_after: got valid/pix_ready=%b%b expected 01", res_valid_out, pix_ready_out); end
      @(negedge clk_in);
      pix_valid_in = 1'b0; sol_in = 1'b0; res_ready_in = 1'b0;
      checks++; if (dones !== 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", dones); end
   endtask

   task automatic test_reset_midline();
      int obs, mt, mf, m1, ml, mn, mx; logic d0, v1, d1;
      gen_line(120);
      for (int i = 0; i < 501; i++) pix[i] = ((i / 100) % 2 == 1) ? 3'b011 : 3'b100;
      drive_line(501, 1'b0, obs);
      checks++; if (obs !== -1) begin errors++; $display("FAIL abort_early_result: got %0d expected -1", obs); end
      rst_n_in = 1'b0; #1;
      checks++; if ({res_valid_out, pix_ready_out, number_of_flips_out} !== {1'b0, 1'b1, 4'd0}) begin errors++;
         $display("FAIL abort_reset: got valid/ready/flips=%b/%b/%0d expected 0/1/0", res_valid_out, pix_ready_out, number_of_flips_out); end
      @(negedge clk_in); rst_n_in = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_in); pix_valid_in = 1'b1; sol_in = 1'b0; rgb_in = CH'($urandom);
         @(posedge clk_in); #1;
         checks++; if (res_valid_out !== 1'b0) begin errors++; $display("FAIL abort_idle%0d: got valid %b expected 0", c, res_valid_out); end
      end
      gen_line(90);
      model_line(mt, mf, m1, ml, mn, mx);
      drive_line(LINE_LEN, 1'b1, obs);
      checks++; if (obs !== mt) begin errors++; $display("FAIL abort_new_term: got %0d expected %0d", obs, mt); end
      checks++; if ({number_of_flips_out, first_coord_out, last_coord_out} !== {FW'(mf), CW'(m1), CW'(ml)}) begin errors++;
         $display("FAIL abort_new_result: got %0d/%0d/%0d expected %0d/%0d/%0d", number_of_flips_out, first_coord_out, last_coord_out, mf, m1, ml); end
      release_result(d0, v1, d1);
   endtask

   task automatic test_sol_restart();
      int obs, mt, mf, m1, ml, mn, mx; logic d0, v1, d1;
      for (int i = 0; i < LINE_LEN; i++) pix[i] = ((i / 70) % 2 == 1) ? 3'b010 : 3'b101;
      drive_line(300, 1'b0, obs);
      checks++; if (obs !== -1) begin errors++; $display("FAIL restart_partial: got %0d expected -1", obs); end
      gen_line(100);
      model_line(mt, mf, m1, ml, mn, mx);
      drive_line(LINE_LEN, 1'b1, obs);
      checks++; if (obs !== mt) begin errors++; $display("FAIL restart_term: got %0d expected %0d", obs, mt); end
      checks++; if ({number_of_flips_out, first_coord_out, last_coord_out} !== {FW'(mf), CW'(m1), CW'(ml)}) begin errors++;
         $display("FAIL restart_result: got %0d/%0d/%0d expected %0d/%0d/%0d", number_of_flips_out, first_coord_out, last_coord_out, mf, m1, ml); end
      release_result(d0, v1, d1);
   endtask

`ifdef RUN_STATS_EN
   task automatic test_run_stats();
      int obs; logic d0, v1, d1;
      for (int i = 0; i < LINE_LEN; i++) pix[i] = (i >= 100 && i <= 249) ? 3'b101 : 3'b000;
      drive_line(LINE_LEN, 1'b0, obs);
      checks++; if ({number_of_flips_out, first_coord_out, last_coord_out} !== {4'd2, 11'd100, 11'd250}) begin errors++;
         $display("FAIL stats_result: got %0d/%0d/%0d expected 2/100/250", number_of_flips_out, first_coord_out, last_coord_out); end
      checks++; if ({min_run_out, max_run_out} !== {11'd100, 11'd150}) begin errors++;
         $display("FAIL stats_runs: got %0d/%0d expected 100/150", min_run_out, max_run_out); end
      release_result(d0, v1, d1);
   endtask
`endif

   initial begin
      test_reset();
      test_band();
      test_glitch();
      test_max_flips();
      test_random();
      test_hold_stall();
      test_reset_midline();
      test_sol_restart();
`ifdef RUN_STATS_EN
      test_run_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
